// File: rtl/crc_checker_par_if.sv
// Codeword-in / result-out handshake bundle for crc_checker_par.
// The master side offers codewords and consumes results; the slave side is the checker.
interface crc_checker_par_if #(
  parameter int DATAWIDTH = 48,
  parameter int CRCWIDTH  = 8
);
  // Codeword handshake
  logic                 in_valid;
  logic                 in_ready;
  logic [DATAWIDTH-1:0] datain;
  logic [CRCWIDTH-1:0]  genpoly;
  logic [CRCWIDTH-1:0]  init;

  // Result handshake
  logic                 out_valid;
  logic                 out_ready;
  logic [CRCWIDTH-1:0]  remainder;
  logic                 crc_error;

  modport master (
    output in_valid, datain, genpoly, init, out_ready,
    input  in_ready, out_valid, remainder, crc_error
  );

  modport slave (
    input  in_valid, datain, genpoly, init, out_ready,
    output in_ready, out_valid, remainder, crc_error
  );
endinterface

// File: rtl/crc_checker_par.sv
// crc_checker_par: divides one DATAWIDTH-bit codeword (message then CRC, MSB first)
// by a generator programmed at accept time, BPC bits per cycle, and returns the
// remainder, an error flag and a saturating count of erroring frames.
module crc_checker_par #(
  parameter int DATAWIDTH = 48,
  parameter int CRCWIDTH  = 8,
  parameter int BPC       = 1,
  parameter int CNTWIDTH  = 16
) (
  input  logic                clk,
  input  logic                resetn,
  crc_checker_par_if.slave    bus,
  input  logic                abort,
  input  logic                clr_count,
  output logic [CNTWIDTH-1:0] err_count
);

  // Message bits still to be shifted through the divider after the top
  // CRCWIDTH codeword bits have been preloaded into crc_reg.
  localparam int MSGWIDTH = DATAWIDTH - CRCWIDTH;
  localparam int NSTEPS   = (BPC > 0) ? MSGWIDTH / BPC : 1;
  localparam int STEPW    = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam logic [STEPW-1:0] LAST_STEP = STEPW'(NSTEPS - 1);

  // Illegal configurations stop elaboration instead of building a broken divider.
  generate
    if (CRCWIDTH < 2 || CRCWIDTH > 32) begin : g_bad_crcwidth
      $error("crc_checker_par: CRCWIDTH must lie in 2..32");
    end
    if (CRCWIDTH >= DATAWIDTH) begin : g_bad_datawidth
      $error("crc_checker_par: CRCWIDTH must be less than DATAWIDTH");
    end
    if (BPC < 1 || (MSGWIDTH % BPC) != 0) begin : g_bad_bpc
      $error("crc_checker_par: BPC must divide DATAWIDTH-CRCWIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t               state;
  state_t               state_next;
  logic                 in_ready_c;
  logic                 out_valid_c;

  logic [CRCWIDTH-1:0]  crc_reg;
  logic [CRCWIDTH-1:0]  crc_next;
  logic [CRCWIDTH-1:0]  poly_reg;
  logic [MSGWIDTH-1:0]  data_sr;
  logic [STEPW-1:0]     step_cnt;
  logic [CRCWIDTH-1:0]  remainder_q;
  logic                 crc_error_q;

  logic                 accept;
  logic                 finish;

  // A codeword is taken only in IDLE; abort there is deliberately ignored.
  assign accept = (state == S_IDLE) && bus.in_valid;

  // The frame completes on the edge that performs the last group of steps,
  // unless it is being aborted in that very cycle.
  assign finish = (state == S_CALC) && !abort && (step_cnt == LAST_STEP);

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.remainder = remainder_q;
  assign bus.crc_error = crc_error_q;

  // State register; a synchronous reset drops any frame in flight without a result.
  always_ff @(posedge clk) begin
    // NOTE: registers take non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the always blocks are evaluated.
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs, decoded from the current state.
  always_comb begin
    // NOTE: every output gets a default before the case, so no path through
    // the block leaves a signal unassigned and no latch is inferred.
    state_next  = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          state_next = S_CALC;
        end
      end
      S_CALC: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (step_cnt == LAST_STEP) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid_c = 1'b1;
        // abort in DONE simply releases the result like out_ready would.
        if (bus.out_ready || abort) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // BPC long-division steps unrolled into one cycle, MSB of data_sr first.
  always_comb begin
    crc_next = crc_reg;
    for (int i = 0; i < BPC; i++) begin
      crc_next = {crc_next[CRCWIDTH-2:0], data_sr[MSGWIDTH-1-i]}
               ^ ({CRCWIDTH{crc_next[CRCWIDTH-1]}} & poly_reg);
    end
  end

  // Divider datapath: load on accept, then shift BPC bits per CALC cycle.
  always_ff @(posedge clk) begin
    // NOTE: the shift and polynomial registers are reset as well, so a reset
    // mid-frame leaves nothing of the discarded codeword behind.
    if (!resetn) begin
      crc_reg  <= '0;
      poly_reg <= '0;
      data_sr  <= '0;
      step_cnt <= '0;
    end else if (accept) begin
      crc_reg  <= bus.datain[DATAWIDTH-1 -: CRCWIDTH] ^ bus.init;
      data_sr  <= bus.datain[MSGWIDTH-1:0];
      poly_reg <= bus.genpoly;
      step_cnt <= '0;
    end else if (state == S_CALC) begin
      crc_reg  <= crc_next;
      data_sr  <= data_sr << BPC;
      step_cnt <= step_cnt + 1'b1;
    end
  end

  // Result registers: captured once per completed frame and held until the next.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      remainder_q <= '0;
      crc_error_q <= 1'b0;
    end else if (finish) begin
      remainder_q <= crc_next;
      crc_error_q <= |crc_next;
    end
  end

  // Saturating count of erroring frames; a clear wins over a coincident increment.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      err_count <= '0;
    end else if (clr_count) begin
      err_count <= '0;
    end else if (finish && (|crc_next) && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_crc_checker_par.sv
// Directed bench for crc_checker_par: three builds (80/8/8 with a 2-bit counter,
// 80/8/1, and the default 48/8/1) driven from one sequence, with a per-build
// scoreboard of expected results filled when a codeword is offered.
module tb_crc_checker_par;

  typedef struct {
    logic [7:0]  rem;
    logic        err;
    logic [31:0] cnt;
  } exp_t;

  typedef struct {
    logic        ov;
    logic        ir;
    logic        err;
    logic [7:0]  rem;
    logic [31:0] cnt;
  } obs_t;

  logic clk = 1'b0;
  logic resetn;

  logic        abort_a, abort_b, abort_c;
  logic        clr_a, clr_b, clr_c;
  logic [1:0]  cnt_a;
  logic [15:0] cnt_b;
  logic [15:0] cnt_c;

  int checks   = 0;
  int failures = 0;

  exp_t sb [3][$];
  int   mcnt [3];
  int   mmax [3];

  always #5 clk = ~clk;

  crc_checker_par_if #(.DATAWIDTH(80), .CRCWIDTH(8)) bus_a ();
  crc_checker_par_if #(.DATAWIDTH(80), .CRCWIDTH(8)) bus_b ();
  crc_checker_par_if #(.DATAWIDTH(48), .CRCWIDTH(8)) bus_c ();

  crc_checker_par #(.DATAWIDTH(80), .CRCWIDTH(8), .BPC(8), .CNTWIDTH(2)) dut_a (
    .clk(clk), .resetn(resetn), .bus(bus_a),
    .abort(abort_a), .clr_count(clr_a), .err_count(cnt_a)
  );

  crc_checker_par #(.DATAWIDTH(80), .CRCWIDTH(8), .BPC(1), .CNTWIDTH(16)) dut_b (
    .clk(clk), .resetn(resetn), .bus(bus_b),
    .abort(abort_b), .clr_count(clr_b), .err_count(cnt_b)
  );

  crc_checker_par dut_c (
    .clk(clk), .resetn(resetn), .bus(bus_c),
    .abort(abort_c), .clr_count(clr_c), .err_count(cnt_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain polynomial long division of the whole codeword by x^n + poly.
  function automatic logic [31:0] crc_model(input logic [79:0] cw, input int dw, input int n,
                                            input logic [31:0] poly, input logic [31:0] iv);
    logic [79:0] r;
    logic [31:0] res;
    r = '0;
    for (int k = 0; k < dw; k++) r[k] = cw[k];
    for (int k = 0; k < n; k++) r[dw-n+k] = r[dw-n+k] ^ iv[k];
    for (int i = dw - 1; i >= n; i--) begin
      if (r[i]) begin
        r[i] = 1'b0;
        for (int k = 0; k < n; k++) r[i-n+k] = r[i-n+k] ^ poly[k];
      end
    end
    res = '0;
    for (int k = 0; k < n; k++) res[k] = r[k];
    return res;
  endfunction

  function automatic obs_t sample(input int w);
    obs_t s;
    case (w)
      0: begin
        s.ov = bus_a.out_valid; s.ir = bus_a.in_ready; s.err = bus_a.crc_error;
        s.rem = bus_a.remainder; s.cnt = 32'(cnt_a);
      end
      1: begin
        s.ov = bus_b.out_valid; s.ir = bus_b.in_ready; s.err = bus_b.crc_error;
        s.rem = bus_b.remainder; s.cnt = 32'(cnt_b);
      end
      default: begin
        s.ov = bus_c.out_valid; s.ir = bus_c.in_ready; s.err = bus_c.crc_error;
        s.rem = bus_c.remainder; s.cnt = 32'(cnt_c);
      end
    endcase
    return s;
  endfunction

  task automatic set_ready(input int w, input logic v, input bit via_abort);
    case (w)
      0: if (via_abort) abort_a = v; else bus_a.out_ready = v;
      1: if (via_abort) abort_b = v; else bus_b.out_ready = v;
      default: if (via_abort) abort_c = v; else bus_c.out_ready = v;
    endcase
  endtask

  // Offer one codeword; returns 1 time unit after the accepting edge E0.
  // exp_rem < 0 takes the expected remainder from the reference model.
  task automatic send(input int w, input logic [79:0] d, input logic [7:0] p,
                      input logic [7:0] iv, input int exp_rem, input bit push);
    exp_t e;
    obs_t s;
    int   dw;
    dw = (w == 2) ? 48 : 80;
    e.rem = (exp_rem < 0) ? crc_model(d, dw, 8, 32'(p), 32'(iv)) : 8'(exp_rem);
    e.err = (e.rem != 8'h00);
    if (push) begin
      if (e.err && mcnt[w] < mmax[w]) mcnt[w]++;
      e.cnt = 32'(mcnt[w]);
      sb[w].push_back(e);
    end
    s = sample(w);
    check("in_ready_before_accept", 32'(s.ir), 32'd1);
    case (w)
      0: begin bus_a.datain = d; bus_a.genpoly = p; bus_a.init = iv; bus_a.in_valid = 1'b1; end
      1: begin bus_b.datain = d; bus_b.genpoly = p; bus_b.init = iv; bus_b.in_valid = 1'b1; end
      default: begin bus_c.datain = d[47:0]; bus_c.genpoly = p; bus_c.init = iv; bus_c.in_valid = 1'b1; end
    endcase
    @(posedge clk);
    #1;
    // Scramble the don't-care inputs while the frame is being divided.
    case (w)
      0: begin
        bus_a.in_valid = 1'b0; bus_a.datain = {$urandom, $urandom, 16'($urandom)};
        bus_a.genpoly = 8'($urandom); bus_a.init = 8'($urandom);
      end
      1: begin
        bus_b.in_valid = 1'b0; bus_b.datain = {$urandom, $urandom, 16'($urandom)};
        bus_b.genpoly = 8'($urandom); bus_b.init = 8'($urandom);
      end
      default: begin
        bus_c.in_valid = 1'b0; bus_c.datain = {$urandom, 16'($urandom)};
        bus_c.genpoly = 8'($urandom); bus_c.init = 8'($urandom);
      end
    endcase
    s = sample(w);
    check("in_ready_low_in_calc", 32'(s.ir), 32'd0);
  endtask

  // Wait (bounded) for a result, compare it with the scoreboard head, optionally
  // hold it for some cycles, then release it with out_ready or abort.
  task automatic recv(input int w, input string tag, input int exp_lat, input int hold,
                      input bit via_abort, output logic [7:0] rem_seen);
    obs_t s;
    exp_t e;
    int   lat;
    lat = 0;
    s = sample(w);
    while (s.ov !== 1'b1 && lat < 500) begin
      @(posedge clk);
      #1;
      lat++;
      s = sample(w);
    end
    rem_seen = s.rem;
    check({tag, "_out_valid"}, 32'(s.ov), 32'd1);
    if (s.ov !== 1'b1) return;
    if (exp_lat >= 0) check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    e = sb[w].pop_front();
    check({tag, "_remainder"}, 32'(s.rem), 32'(e.rem));
    check({tag, "_crc_error"}, 32'(s.err), 32'(e.err));
    check({tag, "_err_count"}, s.cnt, e.cnt);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      s = sample(w);
      check({tag, "_hold_valid"}, 32'(s.ov), 32'd1);
      check({tag, "_hold_remainder"}, 32'(s.rem), 32'(e.rem));
      check({tag, "_hold_in_ready"}, 32'(s.ir), 32'd0);
    end
    set_ready(w, 1'b1, via_abort);
    @(posedge clk);
    #1;
    set_ready(w, 1'b0, via_abort);
    s = sample(w);
    check({tag, "_released_valid"}, 32'(s.ov), 32'd0);
    check({tag, "_released_in_ready"}, 32'(s.ir), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [79:0] good;
    logic [79:0] bad;
    logic [79:0] d;
    logic [7:0]  ra, rb, rx;
    logic        any_ov;
    obs_t        s;
    exp_t        e;

    good = 80'h313233343536373839F4;
    bad  = 80'h31323334353637383900;
    mcnt = '{0, 0, 0};
    mmax = '{3, 65535, 65535};

    resetn = 1'b0;
    abort_a = 1'b0; abort_b = 1'b0; abort_c = 1'b0;
    clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b0; bus_a.datain = '0; bus_a.genpoly = '0; bus_a.init = '0;
    bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b0; bus_b.datain = '0; bus_b.genpoly = '0; bus_b.init = '0;
    bus_c.in_valid = 1'b0; bus_c.out_ready = 1'b0; bus_c.datain = '0; bus_c.genpoly = '0; bus_c.init = '0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;

    // Reset state
    s = sample(0);
    check("reset_a_in_ready", 32'(s.ir), 32'd1);
    check("reset_a_out_valid", 32'(s.ov), 32'd0);
    check("reset_a_remainder", 32'(s.rem), 32'd0);
    check("reset_a_crc_error", 32'(s.err), 32'd0);
    check("reset_a_err_count", s.cnt, 32'd0);
    s = sample(2);
    check("reset_c_in_ready", 32'(s.ir), 32'd1);
    check("reset_c_out_valid", 32'(s.ov), 32'd0);

    // CRC-8/0x07 over "123456789" with its check value appended: clean frame
    send(0, good, 8'h07, 8'h00, 0, 1'b1);
    recv(0, "a_good", 9, 0, 1'b0, rx);

    // Same message with a zero CRC field: remainder is the check value
    send(0, bad, 8'h07, 8'h00, 8'hF4, 1'b1);
    recv(0, "a_bad", 9, 0, 1'b0, rx);

    // Single bit flip, run on the BPC=8 and BPC=1 builds side by side
    d = good;
    d[40] = ~d[40];
    send(1, d, 8'h07, 8'h00, -1, 1'b1);
    send(0, d, 8'h07, 8'h00, -1, 1'b1);
    recv(0, "a_flip", 9, 0, 1'b0, ra);
    recv(1, "b_flip", -1, 0, 1'b0, rb);
    check("flip_remainder_nonzero", 32'(ra != 8'h00), 32'd1);
    check("bpc1_matches_bpc8", 32'(rb), 32'(ra));

    // Nonzero init folds into the top CRC bits
    send(0, good, 8'h07, 8'h5A, -1, 1'b1);
    recv(0, "a_init", 9, 0, 1'b0, rx);

    // Default build, all-zero codeword, result held under back-pressure
    send(2, 80'h0, 8'h07, 8'h00, 0, 1'b1);
    recv(2, "c_zero", 40, 10, 1'b0, rx);
    send(2, {32'h0, 48'h123456789ABC}, 8'h1D, 8'hFF, -1, 1'b1);
    recv(2, "c_mixed", 40, 0, 1'b0, rx);

    // Abort in the fifth CALC cycle: back to IDLE, no result, no count
    send(0, bad, 8'h07, 8'h00, -1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    abort_a = 1'b1;
    @(posedge clk);
    #1;
    abort_a = 1'b0;
    s = sample(0);
    check("abort_in_ready", 32'(s.ir), 32'd1);
    check("abort_out_valid", 32'(s.ov), 32'd0);
    any_ov = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      s = sample(0);
      any_ov = any_ov | s.ov;
    end
    check("abort_no_result", 32'(any_ov), 32'd0);
    check("abort_no_count", s.cnt, 32'(mcnt[0]));

    // abort while IDLE is ignored: this frame is accepted and processed normally
    abort_a = 1'b1;
    send(0, good, 8'h07, 8'h00, 0, 1'b1);
    abort_a = 1'b0;
    recv(0, "a_after_abort", 9, 0, 1'b0, rx);

    // Drive the 2-bit counter into saturation; one result is released by abort
    for (int k = 0; k < 3; k++) begin
      send(0, bad, 8'h07, 8'h00, 8'hF4, 1'b1);
      recv(0, "a_sat", 9, 0, (k == 1), rx);
    end
    s = sample(0);
    check("sat_sticks_at_3", s.cnt, 32'd3);

    // clr_count on the same edge as an erroring DONE entry leaves zero
    send(0, bad, 8'h07, 8'h00, 8'hF4, 1'b1);
    e = sb[0].pop_back();
    e.cnt = 32'd0;
    sb[0].push_back(e);
    mcnt[0] = 0;
    repeat (8) @(posedge clk);
    #1;
    s = sample(0);
    check("clr_pre_edge_valid", 32'(s.ov), 32'd0);
    clr_a = 1'b1;
    @(posedge clk);
    #1;
    clr_a = 1'b0;
    recv(0, "a_clr", -1, 0, 1'b0, rx);

    // Reset in the middle of CALC after the count has moved off zero
    send(0, bad, 8'h07, 8'h00, 8'hF4, 1'b1);
    recv(0, "a_pre_reset", 9, 0, 1'b0, rx);
    send(0, bad, 8'h07, 8'h00, -1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    s = sample(0);
    check("midreset_in_ready", 32'(s.ir), 32'd1);
    check("midreset_out_valid", 32'(s.ov), 32'd0);
    check("midreset_remainder", 32'(s.rem), 32'd0);
    check("midreset_crc_error", 32'(s.err), 32'd0);
    check("midreset_err_count", s.cnt, 32'd0);
    resetn = 1'b1;
    mcnt = '{0, 0, 0};
    any_ov = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      s = sample(0);
      any_ov = any_ov | s.ov;
    end
    check("midreset_no_result", 32'(any_ov), 32'd0);

    // Operational again after the reset
    send(0, good, 8'h07, 8'h00, 0, 1'b1);
    recv(0, "a_after_reset", 9, 0, 1'b0, rx);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
